mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter ADDR, default 16: address width.
REQ-002 The block SHALL have parameter WORD, default 32: data width.
REQ-003 The block SHALL have parameter TIMEOUT, default 16: max cycles waiting for mem_ack_i, minimum 2.

Ports (name, direction, width, meaning):
REQ-004 The block SHALL have these ports:
- clk  in  1  clock; one clock domain, all logic on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- i_req_i  in  1  instruction fetch request (level).
- i_addr_i  in  ADDR  instruction address.
- i_ack_o  out  1  instruction response pulse.
- i_rdata_o  out  WORD  instruction data.
- i_stall_o  out  1  stall to fetch stage.
- d_req_i  in  1  data request (level).
- d_we_i  in  1  data write enable.
- d_addr_i  in  ADDR  data address.
- d_wdata_i  in  WORD  data write value.
- d_ack_o  out  1  data response pulse.
- d_rdata_o  out  WORD  data read value.
- err_o  out  1  timeout pulse, coincident with the failing ack.
- mem_req_o  out  1  memory request, held until acknowledged.
- mem_we_o  out  1  memory write enable.
- mem_addr_o  out  ADDR  memory address.
- mem_wdata_o  out  WORD  memory write data.
- mem_rdata_i  in  WORD  memory read data.
- mem_ack_i  in  1  memory completion, single cycle.

Function
REQ-005 The FSM SHALL have states IDLE, ISSUE and RESP; reset state IDLE.
REQ-006 Requesters SHALL hold req and payload stable until their ack; the arbiter SHALL sample the payload only at grant.
REQ-007 In IDLE, if exactly one req is high, the FSM SHALL grant it, register its addr/we/wdata and go to ISSUE next cycle.
- An instruction grant SHALL force we=0 and wdata=0.
REQ-008 When both reqs are high in IDLE, the FSM SHALL grant the requester not granted last (round-robin); last_grant SHALL reset to instruction, so data wins the first tie.
REQ-009 In ISSUE, mem_req_o SHALL be 1 and mem_we_o/mem_addr_o/mem_wdata_o SHALL drive the registered payload; in every other state all mem_* outputs SHALL be 0.
REQ-010 In ISSUE, mem_ack_i=1 SHALL capture mem_rdata_i into the winner's rdata register and move the FSM to RESP; for writes, d_rdata_o SHALL capture 0.
REQ-011 In RESP, the FSM SHALL assert the winner's ack_o for exactly one cycle, then return to IDLE.
- No grant SHALL occur in RESP.
- The minimum latency is req in cycle 0 -> mem_req_o in cycle 1 -> ack_o in cycle 2 when mem_ack_i arrives in cycle 1.
REQ-012 i_rdata_o and d_rdata_o SHALL hold their last value until overwritten by a new response of the same port.
REQ-013 A wait counter SHALL clear on entry to ISSUE and increment each ISSUE cycle without mem_ack_i.
- When it reaches TIMEOUT-1 with no ack, the FSM SHALL go to RESP with the winner's rdata set to 0.
- In that RESP cycle, err_o SHALL be 1 together with the winner's ack_o.
REQ-014 mem_ack_i arriving outside ISSUE (e.g. late after a timeout) SHALL be ignored.
REQ-015 mem_ack_i in the same cycle the counter reaches TIMEOUT-1 SHALL count as success; err_o SHALL stay 0.
REQ-016 i_stall_o SHALL equal i_req_i AND NOT i_ack_o, combinationally.
REQ-017 A req deasserted while its transaction is in ISSUE SHALL NOT abort it; the ack SHALL still be produced.

Reset
REQ-018 While rst=1 at a clock edge, the block SHALL:
- set the FSM to IDLE and last_grant to instruction;
- clear the wait counter and the registered payload;
- clear i_rdata_o and d_rdata_o to 0.
REQ-019 During and after reset, all outputs SHALL be 0, except i_stall_o, which follows i_req_i.
REQ-020 Reset during ISSUE SHALL abandon the transaction with no ack and no err; the first grant SHALL be possible in the first cycle after rst falls.

Verification
REQ-021 Instruction read: i_req_i=1, i_addr_i=0x0010, mem_ack_i one cycle after mem_req_o with rdata 0xDEADBEEF -> mem_addr_o=0x0010, mem_we_o=0; i_ack_o pulses one cycle with i_rdata_o=0xDEADBEEF; i_stall_o=1 until the ack cycle.
REQ-022 Tie after reset: both reqs high -> data granted first, instruction second; with both held continuously, grants alternate D,I,D,I.
REQ-023 Data write: d_we_i=1, d_addr_i=0x0100, d_wdata_i=0x12345678 -> mem_we_o=1 with that addr/data throughout ISSUE; d_ack_o pulses; d_rdata_o=0; i_ack_o stays 0.
REQ-024 Timeout: mem_ack_i never asserted, TIMEOUT=16 -> mem_req_o high exactly 16 cycles, then ack_o and err_o high together for 1 cycle with rdata=0; a mem_ack_i 2 cycles later is ignored.
REQ-025 Boundary: mem_ack_i in the 16th ISSUE cycle -> success with err_o=0 and data captured.
REQ-026 Reset mid-ISSUE: rst=1 for 1 cycle in the 3rd ISSUE cycle -> mem_req_o=0 next cycle, no ack; a pending i_req_i is regranted in the first cycle after rst falls.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one memory port between instruction fetch and data access,
// with a per-transaction ack timeout.
module mem_arbiter #(
   parameter int ADDR    = 16,
   parameter int WORD    = 32,
   parameter int TIMEOUT = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_req_i,
   input  logic [ADDR-1:0] i_addr_i,
   output logic            i_ack_o,
   output logic [WORD-1:0] i_rdata_o,
   output logic            i_stall_o,
   input  logic            d_req_i,
   input  logic            d_we_i,
   input  logic [ADDR-1:0] d_addr_i,
   input  logic [WORD-1:0] d_wdata_i,
   output logic            d_ack_o,
   output logic [WORD-1:0] d_rdata_o,
   output logic            err_o,
   output logic            mem_req_o,
   output logic            mem_we_o,
   output logic [ADDR-1:0] mem_addr_o,
   output logic [WORD-1:0] mem_wdata_o,
   input  logic [WORD-1:0] mem_rdata_i,
   input  logic            mem_ack_i
);
   localparam int CW = $clog2(TIMEOUT);
   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
   state_t          r_state, w_next;
   logic            r_last_d, r_win_d, r_we, r_err;
   logic [ADDR-1:0] r_addr;
   logic [WORD-1:0] r_wdata, r_i_rdata, r_d_rdata;
   logic [CW-1:0]   r_cnt;
   logic            w_gnt, w_gnt_d, w_tmo, w_done, w_issue, w_resp;
   always_comb begin
      w_gnt   = r_state == IDLE && (i_req_i || d_req_i);
      // on a tie the side that did not win last time gets the port
      w_gnt_d = d_req_i && (!i_req_i || !r_last_d);
      w_tmo   = r_cnt == CW'(TIMEOUT - 1) && !mem_ack_i;
      w_done  = mem_ack_i || w_tmo;
      w_issue = r_state == ISSUE;
      w_resp  = r_state == RESP;
      w_next  = r_state == IDLE  ? (w_gnt ? ISSUE : IDLE) :
                r_state == ISSUE ? (w_done ? RESP : ISSUE) : IDLE;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_last_d  <= 1'b0;
         r_win_d   <= 1'b0;
         r_we      <= 1'b0;
         r_err     <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_cnt     <= '0;
         r_i_rdata <= '0;
         r_d_rdata <= '0;
      end else begin
         r_state <= w_next;
         if (w_gnt) begin
            r_win_d  <= w_gnt_d;
            r_last_d <= w_gnt_d;
            r_we     <= w_gnt_d && d_we_i;
            r_addr   <= w_gnt_d ? d_addr_i : i_addr_i;
            r_wdata  <= w_gnt_d ? d_wdata_i : '0;
            r_cnt    <= '0;
         end
         if (w_issue) begin
            r_err <= w_tmo;
            if (!mem_ack_i) r_cnt <= r_cnt + 1'b1;
            // a timed-out or write response returns zero data
            if (w_done && r_win_d) r_d_rdata <= (mem_ack_i && !r_we) ? mem_rdata_i : '0;
            if (w_done && !r_win_d) r_i_rdata <= mem_ack_i ? mem_rdata_i : '0;
         end
      end
   end
   assign mem_req_o   = w_issue;
   assign mem_we_o    = w_issue && r_we;
   assign mem_addr_o  = w_issue ? r_addr : '0;
   assign mem_wdata_o = w_issue ? r_wdata : '0;
   assign i_ack_o     = w_resp && !r_win_d;
   assign d_ack_o     = w_resp && r_win_d;
   assign err_o       = w_resp && r_err;
   assign i_rdata_o   = r_i_rdata;
   assign d_rdata_o   = r_d_rdata;
   assign i_stall_o   = i_req_i && !i_ack_o;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized transactions checked against a round-robin
// transaction model; a background memory responder acks after a programmable number of request cycles.
module tb_mem_arbiter;
   logic        clk = 1'b0, rst = 1'b1;
   logic        i_req_i = 1'b0, d_req_i = 1'b0, d_we_i = 1'b0;
   logic [15:0] i_addr_i = '0, d_addr_i = '0;
   logic [31:0] d_wdata_i = '0, mem_rdata_i = '0;
   logic        mem_ack_i = 1'b0;
   logic        i_ack_o, i_stall_o, d_ack_o, err_o, mem_req_o, mem_we_o;
   logic [31:0] i_rdata_o, d_rdata_o, mem_wdata_o;
   logic [15:0] mem_addr_o;
   int          n_checks = 0, n_err = 0;
   int          lat = 0;
   logic        extra_ack = 1'b0;
   logic [31:0] mem_val = '0;

   mem_arbiter #(.ADDR(16), .WORD(32), .TIMEOUT(16)) dut (
      .clk(clk), .rst(rst),
      .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_ack_o(i_ack_o), .i_rdata_o(i_rdata_o), .i_stall_o(i_stall_o),
      .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
      .d_ack_o(d_ack_o), .d_rdata_o(d_rdata_o), .err_o(err_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
      .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i));

   always #5 clk = ~clk;

   // memory: ack in the lat-th cycle of a request (lat=0 never), plus an optional stray ack
   initial begin
      int n;
      n = 0;
      forever begin
         @(negedge clk);
         if (mem_req_o === 1'b1) n++;
         else n = 0;
         mem_ack_i   = extra_ack || (mem_req_o === 1'b1 && lat != 0 && n == lat);
         mem_rdata_i = mem_val;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drop();
      step();
      i_req_i = 1'b0;
      d_req_i = 1'b0;
      d_we_i  = 1'b0;
   endtask

   task automatic observe(output int nreq, output logic [15:0] a, output logic we, output logic [31:0] wd,
                          output logic stable, output logic ia, output logic da, output logic er,
                          output logic to, output logic stall_bad);
      nreq = 0; a = '0; we = 1'b0; wd = '0; stable = 1'b1;
      ia = 1'b0; da = 1'b0; er = 1'b0; to = 1'b1; stall_bad = 1'b0;
      for (int c = 0; c < 64; c++) begin
         @(negedge clk);
         if (i_stall_o !== (i_req_i && !i_ack_o)) stall_bad = 1'b1;
         if (mem_req_o === 1'b1) begin
            if (nreq == 0) begin
               a = mem_addr_o; we = mem_we_o; wd = mem_wdata_o;
            end else if ({mem_addr_o, mem_we_o, mem_wdata_o} !== {a, we, wd}) stable = 1'b0;
            nreq++;
         end
         if (i_ack_o === 1'b1 || d_ack_o === 1'b1) begin
            ia = i_ack_o; da = d_ack_o; er = err_o; to = 1'b0;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      for (int k = 0; k < 4; k++) begin
         #1;
         i_req_i = 1'($urandom); d_req_i = 1'($urandom); d_we_i = 1'($urandom);
         i_addr_i = 16'($urandom); d_addr_i = 16'($urandom); d_wdata_i = $urandom;
         @(negedge clk);
         n_checks++;
         if ({i_ack_o, i_rdata_o, d_ack_o, d_rdata_o, err_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got ack=%b/%b err=%b req=%b rdata=%h/%h, need all zero",
                     i_ack_o, d_ack_o, err_o, mem_req_o, i_rdata_o, d_rdata_o);
         end
         n_checks++;
         if (i_stall_o !== i_req_i) begin
            n_err++;
            $display("FAIL reset_stall: got %b need %b", i_stall_o, i_req_i);
         end
         @(posedge clk);
      end
      #1;
      i_req_i = 1'b0; d_req_i = 1'b0; d_we_i = 1'b0;
      rst = 1'b0;
   endtask

   task automatic test_inst_read();
      int nreq; logic [15:0] a; logic we, st, ia, da, er, to, sb; logic [31:0] wd;
      lat = 2; mem_val = 32'hDEADBEEF;
      step();
      i_req_i = 1'b1; i_addr_i = 16'h0010;
      observe(nreq, a, we, wd, st, ia, da, er, to, sb);
      n_checks++;
      if ({to, ia, da, er} !== 4'b0100) begin
         n_err++; $display("FAIL iread_ack: got to/ia/da/err=%b%b%b%b need 0100", to, ia, da, er);
      end
      n_checks++;
      if ({a, we, wd, st} !== {16'h0010, 1'b0, 32'h0, 1'b1}) begin
         n_err++; $display("FAIL iread_mem: got addr=%h we=%b wdata=%h stable=%b need 0010 0 0 1", a, we, wd, st);
      end
      n_checks++;
      if (i_rdata_o !== 32'hDEADBEEF) begin
         n_err++; $display("FAIL iread_rdata: got %h need deadbeef", i_rdata_o);
      end
      n_checks++;
      if (nreq != 2 || sb) begin
         n_err++; $display("FAIL iread_timing: got nreq=%0d stall_bad=%b need 2 0", nreq, sb);
      end
      drop();
      @(negedge clk);
      n_checks++;
      if ({i_ack_o, i_stall_o, mem_req_o} !== 3'b000) begin
         n_err++; $display("FAIL iread_pulse: got ack=%b stall=%b req=%b need 000", i_ack_o, i_stall_o, mem_req_o);
      end
   endtask

   task automatic test_tie();
      int nreq; logic [15:0] a; logic we, st, ia, da, er, to, sb; logic [31:0] wd;
      logic exp_d;
      rst = 1'b1;
      step();
      rst = 1'b0;
      lat = 1; mem_val = 32'hCAFE0001;
      i_req_i = 1'b1; i_addr_i = 16'h00A0;
      d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 16'h00B0;
      for (int k = 0; k < 4; k++) begin
         exp_d = (k % 2) == 0;
         observe(nreq, a, we, wd, st, ia, da, er, to, sb);
         n_checks++;
         if ({to, da, ia} !== {1'b0, exp_d, !exp_d}) begin
            n_err++; $display("FAIL tie_order%0d: got to/da/ia=%b%b%b need 0%b%b", k, to, da, ia, exp_d, !exp_d);
         end
         n_checks++;
         if (a !== (exp_d ? 16'h00B0 : 16'h00A0)) begin
            n_err++; $display("FAIL tie_addr%0d: got %h need %h", k, a, exp_d ? 16'h00B0 : 16'h00A0);
         end
      end
      drop();
   endtask

   task automatic test_write();
      int nreq; logic [15:0] a; logic we, st, ia, da, er, to, sb; logic [31:0] wd;
      lat = 3; mem_val = 32'hFFFF0000;
      step();
      d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 16'h0100; d_wdata_i = 32'h12345678;
      observe(nreq, a, we, wd, st, ia, da, er, to, sb);
      n_checks++;
      if ({to, ia, da, er} !== 4'b0010) begin
         n_err++; $display("FAIL write_ack: got to/ia/da/err=%b%b%b%b need 0010", to, ia, da, er);
      end
      n_checks++;
      if ({a, we, wd, st} !== {16'h0100, 1'b1, 32'h12345678, 1'b1} || nreq != 3) begin
         n_err++; $display("FAIL write_mem: got addr=%h we=%b wdata=%h stable=%b n=%0d", a, we, wd, st, nreq);
      end
      n_checks++;
      if (d_rdata_o !== 32'h0) begin
         n_err++; $display("FAIL write_rdata: got %h need 0", d_rdata_o);
      end
      drop();
   endtask

   task automatic test_timeout();
      int nreq; logic [15:0] a; logic we, st, ia, da, er, to, sb; logic [31:0] wd;
      logic bad;
      lat = 0; mem_val = 32'h55AA55AA;
      step();
      i_req_i = 1'b1; i_addr_i = 16'h0200;
      observe(nreq, a, we, wd, st, ia, da, er, to, sb);
      n_checks++;
      if ({to, ia, da, er} !== 4'b0101 || nreq != 16) begin
         n_err++; $display("FAIL timeout_ack: got to/ia/da/err=%b%b%b%b n=%0d need 0101 16", to, ia, da, er, nreq);
      end
      n_checks++;
      if (i_rdata_o !== 32'h0) begin
         n_err++; $display("FAIL timeout_rdata: got %h need 0", i_rdata_o);
      end
      drop();
      step();
      extra_ack = 1'b1;
      step();
      extra_ack = 1'b0;
      bad = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if ({i_ack_o, d_ack_o, err_o, mem_req_o} !== 4'b0 || i_rdata_o !== 32'h0) bad = 1'b1;
      end
      n_checks++;
      if (bad) begin
         n_err++; $display("FAIL late_ack: got activity after stray ack, need none");
      end
   endtask

   task automatic test_boundary();
      int nreq; logic [15:0] a; logic we, st, ia, da, er, to, sb; logic [31:0] wd;
      lat = 16; mem_val = 32'h0BADF00D;
      step();
      d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 16'h0044;
      observe(nreq, a, we, wd, st, ia, da, er, to, sb);
      n_checks++;
      if ({to, ia, da, er} !== 4'b0010 || nreq != 16) begin
         n_err++; $display("FAIL boundary_ack: got to/ia/da/err=%b%b%b%b n=%0d need 0010 16", to, ia, da, er, nreq);
      end
      n_checks++;
      if (d_rdata_o !== 32'h0BADF00D) begin
         n_err++; $display("FAIL boundary_rdata: got %h need 0badf00d", d_rdata_o);
      end
      drop();
   endtask

   task automatic test_reset_mid();
      int nreq, seen; logic [15:0] a; logic we, st, ia, da, er, to, sb; logic [31:0] wd;
      lat = 0; mem_val = 32'h13579BDF;
      step();
      i_req_i = 1'b1; i_addr_i = 16'h0300;
      seen = 0;
      for (int c = 0; c < 10 && seen < 2; c++) begin
         @(negedge clk);
         if (mem_req_o === 1'b1) seen++;
      end
      n_checks++;
      if (seen != 2) begin
         n_err++; $display("FAIL rstmid_start: got %0d issue cycles need 2", seen);
      end
      step();
      rst = 1'b1;
      step();
      rst = 1'b0; lat = 2;
      @(negedge clk);
      n_checks++;
      if ({mem_req_o, i_ack_o, d_ack_o, err_o} !== 4'b0) begin
         n_err++; $display("FAIL rstmid_abandon: got req/ia/da/err=%b%b%b%b need 0000", mem_req_o, i_ack_o, d_ack_o, err_o);
      end
      @(negedge clk);
      n_checks++;
      if (mem_req_o !== 1'b1 || mem_addr_o !== 16'h0300) begin
         n_err++; $display("FAIL rstmid_regrant: got req=%b addr=%h need 1 0300", mem_req_o, mem_addr_o);
      end
      observe(nreq, a, we, wd, st, ia, da, er, to, sb);
      n_checks++;
      if ({to, ia, er} !== 3'b010 || i_rdata_o !== 32'h13579BDF) begin
         n_err++; $display("FAIL rstmid_done: got to/ia/err=%b%b%b rdata=%h need 010 13579bdf", to, ia, er, i_rdata_o);
      end
      drop();
   endtask

   task automatic test_random();
      int nreq, exp_n; logic [15:0] a; logic we, st, ia, da, er, to, sb; logic [31:0] wd;
      logic m_last_d, exp_d, exp_err;
      logic [31:0] m_i, m_d, exp_v;
      logic [15:0] exp_a; logic exp_we; logic [31:0] exp_wd;
      rst = 1'b1;
      step();
      rst = 1'b0;
      m_last_d = 1'b0; m_i = '0; m_d = '0;
      for (int t = 0; t < 30; t++) begin
         i_req_i = 1'($urandom); d_req_i = 1'($urandom);
         if (!i_req_i && !d_req_i) i_req_i = 1'b1;
         d_we_i = 1'($urandom); i_addr_i = 16'($urandom); d_addr_i = 16'($urandom); d_wdata_i = $urandom;
         lat = $urandom_range(1, 20); mem_val = $urandom;
         exp_d    = d_req_i && (!i_req_i || !m_last_d);
         m_last_d = exp_d;
         exp_n    = lat <= 16 ? lat : 16;
         exp_err  = lat > 16;
         exp_a    = exp_d ? d_addr_i : i_addr_i;
         exp_we   = exp_d && d_we_i;
         exp_wd   = exp_d ? d_wdata_i : 32'h0;
         exp_v    = (exp_err || exp_we) ? 32'h0 : mem_val;
         if (exp_d) m_d = exp_v;
         else m_i = exp_v;
         observe(nreq, a, we, wd, st, ia, da, er, to, sb);
         n_checks++;
         if ({to, da, ia, er} !== {1'b0, exp_d, !exp_d, exp_err} || nreq != exp_n) begin
            n_err++;
            $display("FAIL rand%0d_resp: got to/da/ia/err=%b%b%b%b n=%0d need 0%b%b%b n=%0d",
                     t, to, da, ia, er, nreq, exp_d, !exp_d, exp_err, exp_n);
         end
         n_checks++;
         if ({a, we, wd, st} !== {exp_a, exp_we, exp_wd, 1'b1}) begin
            n_err++;
            $display("FAIL rand%0d_mem: got %h %b %h st=%b need %h %b %h", t, a, we, wd, st, exp_a, exp_we, exp_wd);
         end
         n_checks++;
         if (i_rdata_o !== m_i || d_rdata_o !== m_d) begin
            n_err++;
            $display("FAIL rand%0d_rdata: got %h/%h need %h/%h", t, i_rdata_o, d_rdata_o, m_i, m_d);
         end
         drop();
         step();
      end
   endtask

   initial begin
      test_reset();
      test_inst_read();
      test_tie();
      test_write();
      test_timeout();
      test_boundary();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
